// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl_pkg
// Purpose : Shared definitions for the multiply/divide unit controller:
//           operation encodings, FSM state type, default busy-window lengths
//           and a small decode helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

  // E-stage operation encodings; 6 and 7 are reserved and have no effect.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  // True for the four multi-cycle operations (MULT/MULTU/DIV/DIVU).
  function automatic logic is_arith(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
// Module  : mdu_arith
// Purpose : Purely combinational multiply/divide datapath. Produces the
//           64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU and flags a zero
//           divisor so the controller can leave HI/LO untouched.
// Ports   : op          in  3   operation encoding
//           rs_val      in  32  dividend / multiplicand
//           rt_val      in  32  divisor / multiplier
//           result      out 64  {hi,lo}
//           div_by_zero out 1   divide op with rt_val == 0
// Revision: 1.0 - initial release
// ============================================================================
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] rs_mag, rt_mag, rt_mag_safe, rt_safe;
  logic        [31:0] uq_mag, ur_mag, s_quot, s_rem, u_quot, u_rem;
  logic               rt_zero;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division is done on magnitudes so 0x80000000 / -1 wraps cleanly
  // to 0x80000000 instead of relying on simulator overflow behaviour.
  assign rs_mag      = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign rt_mag      = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign rt_zero     = (rt_val == 32'd0);
  assign rt_mag_safe = rt_zero ? 32'd1 : rt_mag;
  assign rt_safe     = rt_zero ? 32'd1 : rt_val;

  assign uq_mag = rs_mag / rt_mag_safe;
  assign ur_mag = rs_mag % rt_mag_safe;
  assign s_quot = (rs_val[31] ^ rt_val[31]) ? (32'd0 - uq_mag) : uq_mag;
  assign s_rem  = rs_val[31] ? (32'd0 - ur_mag) : ur_mag;
  assign u_quot = rs_val / rt_safe;
  assign u_rem  = rs_val % rt_safe;

  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        result      = {s_rem, s_quot};
        div_by_zero = rt_zero;
      end
      MD_DIVU: begin
        result      = {u_rem, u_quot};
        div_by_zero = rt_zero;
      end
      default: result = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mdu_ctrl
// Purpose : Multiply/divide unit controller. Sequences a fixed-latency busy
//           window for MULT/MULTU/DIV/DIVU, owns architectural HI/LO and
//           stalls D-stage HI/LO instructions that would see an in-flight
//           result.
// Ports   : clk      in  1   core clock
//           reset    in  1   asynchronous active-high reset
//           start    in  1   E-stage MD instruction this cycle
//           op       in  3   operation encoding
//           rs_val   in  32  forwarded GPR[rs]
//           rt_val   in  32  forwarded GPR[rt]
//           cancel   in  1   E-stage flush, suppresses start
//           d_use_md in  1   D-stage instruction touches HI/LO
//           busy     out 1   multi-cycle op in flight
//           stall    out 1   freeze F/D, bubble into E
//           hi       out 32  architectural HI
//           lo       out 32  architectural LO
// Revision: 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        d_use_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        p_hi_q, p_lo_q, hi_q, lo_q;
  logic               p_dz_q;
  logic [63:0]        arith_res;
  logic               arith_dz;
  logic               go;

  mdu_arith u_arith (
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .result      (arith_res),
    .div_by_zero (arith_dz)
  );

  assign busy  = (state_q == ST_RUN);
  assign go    = start & ~cancel & ~busy;
  assign stall = d_use_md & (busy | (start & ~cancel & is_arith(op)));
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_dz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                p_hi_q  <= arith_res[63:32];
                p_lo_q  <= arith_res[31:0];
                p_dz_q  <= arith_dz;
                cnt_q   <= is_arith(op) && (op <= 3'd1) ? CNT_W'(MULT_CYCLES)
                                                        : CNT_W'(DIV_CYCLES);
                state_q <= ST_RUN;
              end
              MD_MTHI: hi_q <= rs_val;
              MD_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            // A zero divisor still burns the full window but leaves HI/LO alone.
            if (!p_dz_q) begin
              hi_q <= p_hi_q;
              lo_q <= p_lo_q;
            end
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Correct pipeline stalling never presents a start while busy.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy));

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_ctrl
// Purpose : Self-checking bench for mdu_ctrl. Stimulus pushes expected HI/LO
//           values with the cycle they must appear into a scoreboard; a
//           monitor on the falling edge pops and compares, and also checks
//           busy/stall against a cycle-window model every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        cancel = 1'b0;
  logic        d_use_md = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel), .d_use_md(d_use_md),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          busy_from = 1;
  int          busy_to = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%08h required=%08h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions.
  task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output logic dz);
    longint          sa, sb_, sp, sq, sr;
    longint unsigned up;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    eh = 32'd0; el = 32'd0; dz = 1'b0;
    case (o)
      3'd0: begin sp = sa * sb_; eh = sp[63:32]; el = sp[31:0]; end
      3'd1: begin up = longint'(a) * longint'(b); eh = up[63:32]; el = up[31:0]; end
      3'd2: begin
        if (b == 0) dz = 1'b1;
        else begin sq = sa / sb_; sr = sa % sb_; el = sq[31:0]; eh = sr[31:0]; end
      end
      3'd3: begin
        if (b == 0) dz = 1'b1;
        else begin el = a / b; eh = a % b; end
      end
      default: ;
    endcase
  endtask

  // Monitor: busy/stall each cycle, HI/LO whenever a scoreboard entry falls due.
  always @(negedge clk) begin
    if (mon_en) begin
      logic eb, es;
      eb = (cyc >= busy_from) && (cyc <= busy_to);
      es = d_use_md && (eb || (start && !cancel && op <= 3'd3));
      check32("busy", {31'd0, busy}, {31'd0, eb});
      check32("stall", {31'd0, stall}, {31'd0, es});
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check32("hi", hi, e.hi);
        check32("lo", lo, e.lo);
      end
    end
  end

  // Issue one instruction at the current cycle; returns after the busy window.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic du);
    int          t, n;
    logic        g, dz;
    logic [31:0] eh, el;
    exp_t        e;
    t = cyc;
    n = 0;
    op = o; rs_val = a; rt_val = b; cancel = c; d_use_md = du; start = 1'b1;
    g = !c;
    if (g && o <= 3'd3) begin
      n = (o <= 3'd1) ? MC : DC;
      ref_model(o, a, b, eh, el, dz);
      if (!dz) begin mhi = eh; mlo = el; end
      busy_from = t + 1;
      busy_to = t + n;
      e.due = t + n + 1;
    end else begin
      if (g && o == 3'd4) mhi = a;
      if (g && o == 3'd5) mlo = a;
      e.due = t + 1;
    end
    e.hi = mhi; e.lo = mlo;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
    for (int i = 0; i < n; i++) begin
      d_use_md = 1'($urandom);
      cancel = 1'($urandom);
      @(posedge clk); #1;
    end
    cancel = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #(200000);
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_stall", {31'd0, stall}, 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);   // MULT -2*3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);   // MULTU
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);   // DIV -7/2
    issue(3'd3, 32'd7, 32'd0, 1'b0, 1'b1);           // DIVU by zero
    issue(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);   // MTLO
    d_use_md = 1'b1;                                 // MFLO in D next cycle
    @(posedge clk); #1;
    issue(3'd4, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b1);   // MTHI
    issue(3'd0, 32'd1000, 32'd1000, 1'b1, 1'b1);     // cancelled MULT
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(3'd6, 32'h5555_5555, 32'd1, 1'b0, 1'b1);   // reserved
    issue(3'd3, 32'hFFFF_FFFF, 32'd7, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a DIV.
    start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd3; cancel = 1'b0; d_use_md = 1'b0;
    busy_from = cyc + 1; busy_to = cyc + DC;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check32("async_rst_busy", {31'd0, busy}, 32'd0);
    check32("async_rst_hi", hi, 32'd0);
    check32("async_rst_lo", lo, 32'd0);
    busy_from = 1; busy_to = 0; mhi = 32'd0; mlo = 32'd0;
    sb.delete();
    #1 reset = 1'b0;
    @(posedge clk); #1;

    issue(3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      issue(o, rand_operand(), rand_operand(), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the pipelined MIPS core. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the E stage and sequences a fixed-latency busy window. Owns the architectural HI/LO registers and drives the pipeline stall for any D-stage HI/LO instruction that would observe an in-flight result. Sits beside the ALU in E; HI/LO outputs feed the E-stage result mux for MFHI/MFLO.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO this cycle
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved
- rs_val  in  32  forwarded GPR[rs] (dividend / multiplicand / MT source)
- rt_val  in  32  forwarded GPR[rt] (divisor / multiplier)
- cancel  in  1  E-stage instruction is being flushed (exception/interrupt); suppresses start this cycle
- d_use_md  in  1  D-stage instruction is any MULT/DIV/MT/MF HI/LO instruction
- busy  out  1  multi-cycle operation in flight
- stall  out  1  freeze F/D, insert bubble into E
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Effective start: go = start & ~cancel & ~busy. When start & busy (cannot occur with correct stall), request ignored; simulation assertion fires.
- States: IDLE, RUN. Counter cnt, width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- IDLE, go with op 0–3: latch result into pending regs p_hi/p_lo, load cnt with MULT_CYCLES or DIV_CYCLES, → RUN.
- IDLE, go with MTHI/MTLO: write hi (or lo) = rs_val at that edge; stay IDLE; busy never rises.
- IDLE, go with op 6–7: no effect.
- RUN: cnt decrements each edge; at the edge where cnt==1, hi<=p_hi, lo<=p_lo, cnt<=0, → IDLE.
- cancel during RUN has no effect; the in-flight op has already passed commit and completes.
- Arithmetic (computed at start from rs_val/rt_val):
  - MULT: signed 32×32→64; hi=product[63:32], lo=product[31:0]. MULTU: unsigned.
  - DIV: signed, quotient truncated toward zero → lo; remainder (sign of dividend) → hi. 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient → lo, remainder → hi.
  - Divisor 0: full DIV_CYCLES busy window still runs; hi/lo unchanged at completion.
- busy = (state==RUN).
- stall = d_use_md & (busy | (start & ~cancel & op<=3)).

## Timing
- Reset: hi=0, lo=0, busy=0, stall=0 (given d_use_md=0), state IDLE, cnt=0, p_hi=p_lo=0. Reset asserted mid-RUN aborts; pending result discarded.
- go for MULT in cycle T: busy high cycles T+1..T+MULT_CYCLES; new hi/lo visible from cycle T+MULT_CYCLES+1. DIV likewise with DIV_CYCLES.
- MTHI/MTLO in cycle T: new value visible from T+1; no stall generated.
- stall is combinational from inputs and state; asserted the same cycle as the issuing start when D holds an MD instruction.
- Back-to-back: a new op may issue in the first cycle after busy falls (start sampled while busy=0).

## Structure
- Shared package: op encodings (MD_MULT…MD_MTLO), default MULT_CYCLES/DIV_CYCLES constants.
- One sub-module: mdu_arith — purely combinational, takes op/rs_val/rt_val, returns 64-bit {hi,lo} result and div_by_zero flag. mdu_ctrl holds FSM, counter, pending and HI/LO registers.

## Test plan
- MULT rs=0xFFFFFFFE(−2), rt=3 → busy cycles T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA from T+6; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=−7, rt=2 → lo=0xFFFFFFFD(−3), hi=0xFFFFFFFF(−1) after 10 busy cycles; DIVU rs=7, rt=0 → busy 10 cycles, hi/lo unchanged.
- d_use_md=1 while DIV in flight → stall high every busy cycle and in the issue cycle; drops the cycle busy falls.
- MTLO rs=0x12345678 then MFLO next cycle → lo=0x12345678 at T+1, stall never asserted.
- start with cancel=1 (MULT) → busy stays 0, hi/lo unchanged; cancel=1 mid-RUN → op still completes with correct result.
- reset pulsed asynchronously mid-DIV → busy, hi, lo go to 0 immediately without a clock edge; next op runs normally.
